// File: rtl/pcu_pkg.sv
// Shared types and constants for the pipeline trap controller.
// Build macro PCU_MRET_EN adds the RETURN state used by mret.
package pcu_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_MTVAL,
    SET_MEPC,
    SET_MCAUSE,
    JUMP
`ifdef PCU_MRET_EN
    ,
    RETURN
`endif
  } state_t;

  typedef enum logic [3:0] {
    No_Error        = 4'd0,
    Is_Breakpoint   = 4'd1,
    Is_Div_Zero     = 4'd2,
    Is_Mem_Error    = 4'd3,
    Is_Decode_Error = 4'd4
  } cause_t;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

endpackage

// File: rtl/pcu_csr_file.sv
// Machine trap CSRs (mtvec, mepc, mcause, mtval) with hardware/software
// write arbitration and a combinational read port.
import pcu_pkg::*;

module pcu_csr_file #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hw_mtval_we,
  input  logic             hw_mepc_we,
  input  logic             hw_mcause_we,
  input  logic [XLEN-1:0]  hw_mtval,
  input  logic [XLEN-1:0]  hw_mepc,
  input  logic [XLEN-1:0]  hw_mcause,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  output logic [XLEN-1:0]  csr_rdata,
  output logic [XLEN-1:0]  mtvec,
  output logic [XLEN-1:0]  mepc
);

  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  // Trap-sequence writes take precedence over a software write to the same CSR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtvec    <= MTVEC_RST;
      mepc     <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      if (csr_we && csr_addr == CSR_MTVEC)
        mtvec <= {csr_wdata[XLEN-1:2], 2'b00};

      if (hw_mepc_we)
        mepc <= hw_mepc;
      else if (csr_we && csr_addr == CSR_MEPC)
        mepc <= csr_wdata;

      if (hw_mcause_we)
        mcause_q <= hw_mcause;
      else if (csr_we && csr_addr == CSR_MCAUSE)
        mcause_q <= csr_wdata;

      if (hw_mtval_we)
        mtval_q <= hw_mtval;
      else if (csr_we && csr_addr == CSR_MTVAL)
        mtval_q <= csr_wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MTVEC:  csr_rdata = mtvec;
      CSR_MEPC:   csr_rdata = mepc;
      CSR_MCAUSE: csr_rdata = mcause_q;
      CSR_MTVAL:  csr_rdata = mtval_q;
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: rtl/pipe_trap_ctrl.sv
// Pipeline stall/flush control plus the trap entry sequence.
// Define PCU_MRET_EN to enable mret handling through the RETURN state.
import pcu_pkg::*;

module pipe_trap_ctrl #(
  parameter int               XLEN      = 32,
  parameter int               NREG      = 4,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall_req,
  input  logic             redirect,
  input  logic [3:0]       error,
  input  logic [XLEN-1:0]  error_pc,
  input  logic [XLEN-1:0]  error_info,
  input  logic             mret,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  output logic [XLEN-1:0]  csr_rdata,
  output logic [NREG-1:0]  stage_wen,
  output logic [NREG-1:0]  stage_clear,
  output logic             pc_wen,
  output logic             pc_load,
  output logic [XLEN-1:0]  pc_target,
  output logic             trap_busy
);

  state_t          state;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] info_q;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            trap_req;
  logic            mret_go;

  assign trap_req = (error != 4'(No_Error));

`ifdef PCU_MRET_EN
  assign mret_go = mret;
`else
  logic unused_mret;
  assign mret_go     = 1'b0;
  assign unused_mret = mret ^ (^mepc);
`endif

  pcu_csr_file #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST)
  ) u_csr (
    .clk          (clk),
    .rstn         (rstn),
    .hw_mtval_we  (state == SET_MTVAL),
    .hw_mepc_we   (state == SET_MEPC),
    .hw_mcause_we (state == SET_MCAUSE),
    .hw_mtval     (info_q),
    .hw_mepc      (epc_q),
    .hw_mcause    ({{(XLEN-4){1'b0}}, cause_q}),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .mtvec        (mtvec),
    .mepc         (mepc)
  );

  // Requests arriving outside RUN are dropped, never queued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= RUN;
      cause_q <= '0;
      epc_q   <= '0;
      info_q  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (trap_req) begin
            cause_q <= error;
            epc_q   <= error_pc;
            info_q  <= error_info;
            state   <= SET_MTVAL;
          end else if (mret_go) begin
`ifdef PCU_MRET_EN
            state <= RETURN;
`endif
          end
        end
        SET_MTVAL:  state <= SET_MEPC;
        SET_MEPC:   state <= SET_MCAUSE;
        SET_MCAUSE: state <= JUMP;
        default:    state <= RUN;
      endcase
    end
  end

  // Outputs fall back to free-running pipeline values whenever reset is held.
  always_comb begin
    stage_wen   = '1;
    stage_clear = '0;
    pc_wen      = 1'b1;
    pc_load     = 1'b0;
    pc_target   = mtvec;
    trap_busy   = 1'b0;
    if (rstn) begin
      trap_busy = (state != RUN);
      case (state)
        RUN: begin
          if (trap_req || mret_go) begin
            stage_clear = '1;
            pc_wen      = 1'b0;
          end else if (redirect) begin
            stage_clear[1:0] = 2'b11;
          end else if (stall_req) begin
            pc_wen         = 1'b0;
            stage_wen[0]   = 1'b0;
            stage_clear[1] = 1'b1;
          end
        end
        JUMP: begin
          stage_clear = '1;
          pc_load     = 1'b1;
        end
`ifdef PCU_MRET_EN
        RETURN: begin
          stage_clear = '1;
          pc_load     = 1'b1;
          pc_target   = mepc;
        end
`endif
        default: begin
          stage_clear = '1;
          pc_wen      = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_trap_ctrl.sv
// Self-checking bench for pipe_trap_ctrl: directed scenarios then random
// traffic, compared against a cycle-count reference model.
import pcu_pkg::*;

module tb_pipe_trap_ctrl;

  localparam int XLEN = 32;
  localparam int NREG = 4;
`ifdef PCU_MRET_EN
  localparam bit MRET_EN = 1'b1;
`else
  localparam bit MRET_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            stall_req = 1'b0;
  logic            redirect = 1'b0;
  logic [3:0]      error = 4'd0;
  logic [XLEN-1:0] error_pc = '0;
  logic [XLEN-1:0] error_info = '0;
  logic            mret = 1'b0;
  logic            csr_we = 1'b0;
  logic [11:0]     csr_addr = 12'h0;
  logic [XLEN-1:0] csr_wdata = '0;
  logic [XLEN-1:0] csr_rdata;
  logic [NREG-1:0] stage_wen;
  logic [NREG-1:0] stage_clear;
  logic            pc_wen;
  logic            pc_load;
  logic [XLEN-1:0] pc_target;
  logic            trap_busy;

  always #5 clk = ~clk;

  pipe_trap_ctrl #(.XLEN(XLEN), .NREG(NREG), .MTVEC_RST(32'h0000_1000)) dut (
    .clk(clk), .rstn(rstn), .stall_req(stall_req), .redirect(redirect),
    .error(error), .error_pc(error_pc), .error_info(error_info), .mret(mret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .stage_wen(stage_wen), .stage_clear(stage_clear),
    .pc_wen(pc_wen), .pc_load(pc_load), .pc_target(pc_target),
    .trap_busy(trap_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: CSR values, the trap capture, edges since the trap was
  // taken (0 = not trapping, 4 = the jump cycle) and a pending mret return.
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
  logic [31:0] sv_pc, sv_info;
  logic [3:0]  sv_cause;
  int          trap_edges;
  bit          ret_cycle;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      CSR_MTVEC:  return m_mtvec;
      CSR_MEPC:   return m_mepc;
      CSR_MCAUSE: return m_mcause;
      CSR_MTVAL:  return m_mtval;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtvec = 32'h1000; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    sv_pc = 0; sv_info = 0; sv_cause = 0; trap_edges = 0; ret_cycle = 0;
  endtask

  task automatic model_edge(input logic [3:0] er, input logic [31:0] epc, input logic [31:0] einfo,
                            input logic mr, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    if (we) begin
      case (addr)
        CSR_MTVEC:  m_mtvec  = wd & 32'hFFFF_FFFC;
        CSR_MEPC:   m_mepc   = wd;
        CSR_MCAUSE: m_mcause = wd;
        CSR_MTVAL:  m_mtval  = wd;
        default: ;
      endcase
    end
    if (trap_edges == 1) m_mtval = sv_info;
    if (trap_edges == 2) m_mepc = sv_pc;
    if (trap_edges == 3) m_mcause = {28'h0, sv_cause};
    if (trap_edges != 0) begin
      trap_edges = (trap_edges == 4) ? 0 : trap_edges + 1;
    end else if (ret_cycle) begin
      ret_cycle = 0;
    end else if (er != 0) begin
      sv_cause = er; sv_pc = epc; sv_info = einfo; trap_edges = 1;
    end else if (MRET_EN && mr) begin
      ret_cycle = 1;
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rd, input logic [3:0] er,
                               input logic [31:0] epc, input logic [31:0] einfo, input logic mr,
                               input logic we, input logic [11:0] addr, input logic [31:0] wd);
    logic [3:0]  e_wen, e_clr;
    logic        e_pcw, e_load, e_busy;
    logic [31:0] e_tgt;
    bit          chk_pipe;
    @(negedge clk);
    stall_req = st; redirect = rd; error = er; error_pc = epc; error_info = einfo;
    mret = mr; csr_we = we; csr_addr = addr; csr_wdata = wd;
    #1;
    e_wen = 4'b1111; e_clr = 4'b0000; e_pcw = 1; e_load = 0; e_busy = 1;
    e_tgt = m_mtvec; chk_pipe = 1;
    if (trap_edges >= 1 && trap_edges <= 3) begin
      e_clr = 4'b1111; e_pcw = 0;
    end else if (trap_edges == 4) begin
      e_clr = 4'b1111; e_load = 1;
    end else if (ret_cycle) begin
      e_clr = 4'b1111; e_load = 1; e_tgt = m_mepc;
    end else begin
      e_busy = 0;
      if (er != 0) begin
        e_clr = 4'b1111; e_pcw = 0;
      end else if (MRET_EN && mr) begin
        chk_pipe = 0;
      end else if (rd) begin
        e_clr = 4'b0011;
      end else if (st) begin
        e_pcw = 0; e_wen = 4'b1110; e_clr = 4'b0010;
      end
    end
    checkOutput("trap_busy", 32'(trap_busy), 32'(e_busy));
    checkOutput("csr_rdata", csr_rdata, model_read(addr));
    if (chk_pipe) begin
      checkOutput("stage_wen", 32'(stage_wen), 32'(e_wen));
      checkOutput("stage_clear", 32'(stage_clear), 32'(e_clr));
      checkOutput("pc_wen", 32'(pc_wen), 32'(e_pcw));
      checkOutput("pc_load", 32'(pc_load), 32'(e_load));
      if (e_load) checkOutput("pc_target", pc_target, e_tgt);
    end
    @(posedge clk);
    model_edge(er, epc, einfo, mr, we, addr, wd);
  endtask

  task automatic idle(input int n, input logic [11:0] addr);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, addr, 0);
  endtask

  task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    @(negedge clk);
    stall_req = 0; redirect = 0; error = 0; mret = 0; csr_we = 0; csr_addr = addr;
    #1;
    checkOutput(tag, csr_rdata, exp);
    @(posedge clk);
    model_edge(0, 0, 0, 0, 0, addr, 0);
  endtask

  // Reset is asserted away from the clock edge with every request active.
  task automatic do_reset(input logic [11:0] addr);
    @(negedge clk);
    #2;
    rstn = 0; stall_req = 1; redirect = 1; error = 4'd3; mret = 1;
    csr_we = 1; csr_addr = addr; csr_wdata = 32'hFFFF_FFFF;
    #1;
    model_reset();
    checkOutput("rst_stage_wen", 32'(stage_wen), 32'h0000_000F);
    checkOutput("rst_stage_clear", 32'(stage_clear), 32'h0);
    checkOutput("rst_pc_wen", 32'(pc_wen), 32'h1);
    checkOutput("rst_pc_load", 32'(pc_load), 32'h0);
    checkOutput("rst_trap_busy", 32'(trap_busy), 32'h0);
    checkOutput("rst_csr_rdata", csr_rdata, model_read(addr));
    @(negedge clk);
    stall_req = 0; redirect = 0; error = 0; mret = 0; csr_we = 0; csr_wdata = 0;
    rstn = 1;
  endtask

  initial begin
    logic [11:0] addrs [6];
    addrs = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, 12'h300, 12'h344};
    model_reset();

    do_reset(CSR_MTVEC);
    peek("mtvec_reset", CSR_MTVEC, 32'h1000);
    idle(1, CSR_MTVEC);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, CSR_MTVEC, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, CSR_MTVEC, 0);

    applyStimulus(0, 0, 4'd2, 32'h40, 32'h0, 0, 0, CSR_MTVEC, 0);
    idle(4, CSR_MTVEC);
    peek("mepc_after_trap", CSR_MEPC, 32'h40);
    peek("mcause_after_trap", CSR_MCAUSE, 32'h2);
    peek("mtval_after_trap", CSR_MTVAL, 32'h0);

    applyStimulus(0, 0, 4'd2, 32'h44, 32'h9, 0, 0, CSR_MCAUSE, 0);
    idle(1, CSR_MCAUSE);
    applyStimulus(0, 0, 4'd3, 32'h48, 32'h7, 0, 0, CSR_MCAUSE, 0);
    idle(1, CSR_MCAUSE);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, CSR_MCAUSE, 0);
    idle(1, CSR_MCAUSE);
    peek("mcause_first_cause", CSR_MCAUSE, 32'h2);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, CSR_MTVEC, 32'h2003);
    peek("mtvec_aligned", CSR_MTVEC, 32'h2000);
    applyStimulus(0, 0, 4'd1, 32'h80, 32'h1234, 0, 0, CSR_MEPC, 0);
    idle(1, CSR_MEPC);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, CSR_MEPC, 32'hDEAD);
    idle(2, CSR_MEPC);
    peek("mepc_hw_wins", CSR_MEPC, 32'h80);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, CSR_MEPC, 0);
    idle(2, CSR_MEPC);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 12'h300, 32'h55);
    peek("unmapped_read", 12'h300, 32'h0);

    applyStimulus(0, 0, 4'd4, 32'h90, 32'h55, 0, 0, CSR_MTVAL, 0);
    idle(2, CSR_MTVAL);
    do_reset(CSR_MTVAL);
    idle(1, CSR_MTVAL);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) == 0, ($urandom % 4) == 0,
                    (($urandom % 10) == 0) ? 4'($urandom_range(1, 4)) : 4'd0,
                    $urandom, $urandom, ($urandom % 10) == 0, ($urandom % 5) == 0,
                    addrs[$urandom_range(0, 5)], $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_trap_ctrl.md
PIPE_TRAP_CTRL -- requirements
Module: pipe_trap_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath/CSR width.
REQ-002 The block SHALL have parameter NREG, default 4, giving the pipeline register count; index 0 = IF/ID.
REQ-003 The block SHALL have parameter MTVEC_RST, default 32'h0000_1000, giving the mtvec reset value.
REQ-004 The block SHALL have these ports:
  clk  in  1  single clock.
  rstn  in  1  asynchronous active-low reset.
  stall_req  in  1  load-use stall request from the hazard unit.
  redirect  in  1  EX-stage taken branch/jump.
  error  in  4  trap cause: 0 none, 1 breakpoint, 2 div-by-0, 3 mem access, 4 decode.
  error_pc  in  XLEN  PC of the faulting instruction.
  error_info  in  XLEN  trap value.
  mret  in  1  mret reached commit.
  csr_we  in  1  software CSR write.
  csr_addr  in  12  CSR address.
  csr_wdata  in  XLEN  CSR write data.
  csr_rdata  out  XLEN  combinational CSR read.
  stage_wen  out  NREG  per-register write enable.
  stage_clear  out  NREG  per-register synchronous clear.
  pc_wen  out  1  PC write enable.
  pc_load  out  1  PC takes pc_target instead of the normal next PC.
  pc_target  out  XLEN  trap vector or return address.
  trap_busy  out  1  high in every non-RUN state.

Function
REQ-005 FSM states SHALL be: RUN, SET_MTVAL, SET_MEPC, SET_MCAUSE, JUMP, RETURN.
REQ-006 In RUN, the first match in priority order SHALL apply: error != 0 > mret > redirect > stall_req > normal.
REQ-007 On error != 0 in RUN, the cycle SHALL drive stage_clear = all ones, stage_wen = all ones, and pc_wen = 0.
REQ-008 On error != 0 in RUN, error, error_pc and error_info SHALL be latched at the clock edge, and the FSM SHALL go to SET_MTVAL.
REQ-009 SET_MTVAL, SET_MEPC and SET_MCAUSE SHALL each last one cycle and write mtval, mepc and mcause = {1'b0, zero-extended cause}, in that order.
REQ-010 In SET_MTVAL, SET_MEPC and SET_MCAUSE, the outputs SHALL be: stage_clear all ones, pc_wen 0.
REQ-011 JUMP SHALL drive pc_wen = 1, pc_load = 1, pc_target = mtvec, and stage_clear all ones, then return to RUN.
REQ-012 Trap latency SHALL be: error sampled at edge t; PC = mtvec after edge t+4; first handler fetch in cycle t+4.
REQ-013 On mret in RUN, the FSM SHALL enter RETURN for one cycle, driving pc_wen = 1, pc_load = 1, pc_target = mepc, and stage_clear all ones, then go to RUN.
REQ-014 On redirect, stage_clear[0] and stage_clear[1] SHALL be 1, and pc_wen SHALL be 1 (the branch target comes from the datapath; pc_load = 0).
REQ-015 On stall_req, pc_wen = 0 and stage_wen[0] = 0 SHALL hold, stage_clear[1] SHALL be 1, and all other stage_wen SHALL be 1.
REQ-016 Normal operation SHALL drive stage_wen all ones, stage_clear all zeros, pc_wen 1, and pc_load 0.
REQ-017 error, mret, redirect and stall_req SHALL be ignored outside RUN, with no queuing.
REQ-018 CSR map: 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval.
REQ-019 Unmapped CSR addresses SHALL read 0 and ignore writes.
REQ-020 Writes to mtvec SHALL force bits [1:0] to 0 (direct mode only).
REQ-021 When a hardware write from REQ-009 and csr_we target the same CSR in the same cycle, the hardware write SHALL win.
REQ-022 A csr_we write SHALL be visible on csr_rdata in the next cycle.

Reset
REQ-023 rstn low SHALL asynchronously force state RUN, mtvec = MTVEC_RST, and mepc, mcause, mtval and the latches = 0.
REQ-024 While rstn is low, outputs SHALL take their normal values: stage_wen all ones, stage_clear 0, pc_wen 1, pc_load 0, and trap_busy 0.
REQ-025 Reset asserted mid-trap SHALL abandon the sequence, with no partial CSR writes retained.

Configuration
REQ-026 Macro PCU_MRET_EN SHALL control mret support.
REQ-027 With PCU_MRET_EN defined, mret and the RETURN state SHALL exist as specified.
REQ-028 Without PCU_MRET_EN, the RETURN state SHALL be absent, the mret input SHALL be ignored, and mepc SHALL be reachable only via the CSR read port.

Structure
REQ-029 Package pcu_pkg SHALL hold the state enum, the cause code constants (No_Error..Is_Decode_Error) and the CSR address constants.
REQ-030 Sub-module pcu_csr_file SHALL contain the four CSRs, write arbitration and the read mux; the FSM and stage-control decode SHALL stay in pipe_trap_ctrl.

Verification
REQ-031 The bench SHALL cover these scenarios:
  - Reset, then idle: stage_wen = 4'b1111, stage_clear = 0, pc_wen = 1, and csr_rdata at 0x305 = 32'h1000.
  - stall_req one cycle: pc_wen = 0, stage_wen = 4'b1110, stage_clear = 4'b0010.
  - redirect together with stall_req: stage_clear = 4'b0011, pc_wen = 1 (redirect wins).
  - error = 2, error_pc = 0x40, error_info = 0: four cycles later pc_target = 0x1000 with pc_load = 1; then mepc = 0x40, mcause = 2, mtval = 0.
  - error = 3 during SET_MEPC, and mret during JUMP: both ignored, and mcause remains the first cause.
  - Write mtvec = 0x2003, then mret after a trap at 0x80: mtvec reads 0x2000; RETURN drives pc_target = 0x80. Without PCU_MRET_EN, PC is unchanged.
